// File: rtl/tlv_pkg.sv
// Shared constants, register map and FSM encoding for the TLV header encoder.
// Optional build macro used by the top level: TLV_ENC_CLEAR_EN.
package tlv_pkg;

  localparam int unsigned BUF_W     = 192;
  localparam int unsigned BUF_BYTES = BUF_W / 8;
  localparam int unsigned MAX_HDR   = 14;

  localparam logic [7:0] TLV_PFX_16 = 8'hFD;
  localparam logic [7:0] TLV_PFX_32 = 8'hFE;
  localparam logic [7:0] TLV_PFX_64 = 8'hFF;
  localparam logic [63:0] TLV_MAX_1B = 64'h0000_0000_0000_00FC;

  localparam logic [2:0] ADDR_TYPE     = 3'd0;
  localparam logic [2:0] ADDR_LEN      = 3'd1;
  localparam logic [2:0] ADDR_OFF      = 3'd2;
  localparam logic [2:0] ADDR_CTRL     = 3'd3;
  localparam logic [2:0] ADDR_OBUF_HI  = 3'd4;
  localparam logic [2:0] ADDR_OBUF_MID = 3'd5;
  localparam logic [2:0] ADDR_OBUF_LO  = 3'd6;
  localparam logic [2:0] ADDR_VOFF     = 3'd7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StEnc  = 2'd1,
    StDone = 2'd2
  } tlv_state_e;

  // Byte idx of one varint field: prefix first (if any), then the value big-endian.
  function automatic logic [7:0] tlv_field_byte(input logic [63:0] v, input logic [3:0] flen,
                                                input logic pfx_en, input logic [7:0] pfx,
                                                input logic [3:0] idx);
    logic [3:0] sh;
    if (pfx_en && idx == 4'd0) begin
      return pfx;
    end
    sh = flen - 4'd1 - idx;
    return 8'(v >> {sh, 3'b000});
  endfunction

endpackage

// File: rtl/tlv_varint_sizer.sv
// Combinational varint sizing: picks the prefix byte and total field length for a value.
module tlv_varint_sizer
  import tlv_pkg::*;
(
  input  logic [63:0] i_value,
  input  logic        i_is_type,
  output logic [7:0]  o_prefix,
  output logic        o_pfx_en,
  output logic [3:0]  o_len
);

  always_comb begin
    o_prefix = 8'h00;
    o_pfx_en = 1'b0;
    o_len    = 4'd1;
    if (i_value <= TLV_MAX_1B) begin
      o_len = 4'd1;
    end else if (i_value <= 64'h0000_0000_0000_FFFF) begin
      o_prefix = TLV_PFX_16;
      o_pfx_en = 1'b1;
      o_len    = 4'd3;
    end else if (i_is_type || i_value <= 64'h0000_0000_FFFF_FFFF) begin
      // Type is at most 32 bits, so it never needs the 64-bit form.
      o_prefix = TLV_PFX_32;
      o_pfx_en = 1'b1;
      o_len    = 4'd5;
    end else begin
      o_prefix = TLV_PFX_64;
      o_pfx_en = 1'b1;
      o_len    = 4'd9;
    end
  end

endmodule

// File: rtl/tlv_encoder.sv
// CPU-mapped TLV header builder: serialises type/length varints into a 192-bit buffer.
// Build macro TLV_ENC_CLEAR_EN: start also zeroes the whole output buffer.
module tlv_encoder
  import tlv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] cpu_din,
  input  logic [63:0] cpu_ain,
  input  logic        cpu_wren,
  output logic [63:0] cpu_dout
);

  tlv_state_e r_state, w_state_nx;

  logic [31:0]      r_type;
  logic [63:0]      r_len;
  logic [2:0]       r_off;
  logic [31:0]      r_sh_type;
  logic [63:0]      r_sh_len;
  logic [3:0]       r_tlen, r_llen;
  logic [7:0]       r_tpfx, r_lpfx;
  logic             r_tpfx_en, r_lpfx_en;
  logic [7:0]       r_hdr_len;
  logic [4:0]       r_ptr;
  logic [3:0]       r_cnt;
  logic [BUF_W-1:0] r_obuf;
  logic [63:0]      r_dout;

  logic        w_wr_ok, w_wr_type, w_wr_len, w_wr_off, w_start, w_last;
  logic [31:0] w_type_nx;
  logic [63:0] w_len_nx;
  logic [2:0]  w_off_nx;
  logic [7:0]  w_tpfx, w_lpfx;
  logic        w_tpfx_en, w_lpfx_en;
  logic [3:0]  w_tlen, w_llen;
  logic [7:0]  w_hdr [MAX_HDR];
  logic [7:0]  w_byte;
  logic [63:0] w_rd_data;
  logic        w_unused_ain;

  assign w_unused_ain = ^cpu_ain[63:3];

  // Writes to the RO half and all writes while encoding are dropped.
  assign w_wr_ok   = cpu_wren && !cpu_ain[2] && (r_state != StEnc);
  assign w_wr_type = w_wr_ok && (cpu_ain[2:0] == ADDR_TYPE);
  assign w_wr_len  = w_wr_ok && (cpu_ain[2:0] == ADDR_LEN);
  assign w_wr_off  = w_wr_ok && (cpu_ain[2:0] == ADDR_OFF);
  assign w_start   = w_wr_ok && (cpu_ain[2:0] == ADDR_CTRL) && cpu_din[0];

  assign w_type_nx = w_wr_type ? cpu_din[31:0] : r_type;
  assign w_len_nx  = w_wr_len  ? cpu_din       : r_len;
  assign w_off_nx  = w_wr_off  ? cpu_din[2:0]  : r_off;

  tlv_varint_sizer u_type_sizer (
    .i_value   ({32'b0, w_type_nx}),
    .i_is_type (1'b1),
    .o_prefix  (w_tpfx),
    .o_pfx_en  (w_tpfx_en),
    .o_len     (w_tlen)
  );

  tlv_varint_sizer u_len_sizer (
    .i_value   (w_len_nx),
    .i_is_type (1'b0),
    .o_prefix  (w_lpfx),
    .o_pfx_en  (w_lpfx_en),
    .o_len     (w_llen)
  );

  always_comb begin
    for (int i = 0; i < MAX_HDR; i++) begin
      w_hdr[i] = 8'h00;
      if (4'(i) < r_tlen) begin
        w_hdr[i] = tlv_field_byte({32'b0, r_sh_type}, r_tlen, r_tpfx_en, r_tpfx, 4'(i));
      end else begin
        w_hdr[i] = tlv_field_byte(r_sh_len, r_llen, r_lpfx_en, r_lpfx, 4'(i) - r_tlen);
      end
    end
  end

  assign w_byte = w_hdr[r_cnt];
  assign w_last = (r_cnt == 4'(r_hdr_len - 8'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      StIdle, StDone: if (w_start) w_state_nx = StEnc;
      StEnc:          if (w_last)  w_state_nx = StDone;
      default:        w_state_nx = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_type    <= '0;
      r_len     <= '0;
      r_off     <= '0;
      r_sh_type <= '0;
      r_sh_len  <= '0;
      r_tlen    <= '0;
      r_llen    <= '0;
      r_tpfx    <= '0;
      r_lpfx    <= '0;
      r_tpfx_en <= 1'b0;
      r_lpfx_en <= 1'b0;
      r_hdr_len <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_obuf    <= '0;
    end else begin
      r_type <= w_type_nx;
      r_len  <= w_len_nx;
      r_off  <= w_off_nx;
      if (w_start) begin
        r_sh_type <= w_type_nx;
        r_sh_len  <= w_len_nx;
        r_tlen    <= w_tlen;
        r_llen    <= w_llen;
        r_tpfx    <= w_tpfx;
        r_lpfx    <= w_lpfx;
        r_tpfx_en <= w_tpfx_en;
        r_lpfx_en <= w_lpfx_en;
        r_hdr_len <= {4'b0, w_tlen} + {4'b0, w_llen};
        r_ptr     <= {2'b0, w_off_nx};
        r_cnt     <= '0;
`ifdef TLV_ENC_CLEAR_EN
        r_obuf    <= '0;
`else
        r_obuf    <= r_obuf;
`endif
      end else if (r_state == StEnc) begin
        for (int b = 0; b < BUF_BYTES; b++) begin
          if (r_ptr == 5'(b)) r_obuf[BUF_W-1-8*b -: 8] <= w_byte;
        end
        r_ptr <= r_ptr + 5'd1;
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    unique case (cpu_ain[2:0])
      ADDR_TYPE:     w_rd_data = {32'b0, r_type};
      ADDR_LEN:      w_rd_data = r_len;
      ADDR_OFF:      w_rd_data = {61'b0, r_off};
      ADDR_CTRL:     w_rd_data = {54'b0, (r_state == StEnc), (r_state == StDone), r_hdr_len};
      ADDR_OBUF_HI:  w_rd_data = r_obuf[191:128];
      ADDR_OBUF_MID: w_rd_data = r_obuf[127:64];
      ADDR_OBUF_LO:  w_rd_data = r_obuf[63:0];
      ADDR_VOFF:     w_rd_data = {56'b0, r_hdr_len};
      default:       w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout <= '0;
    end else begin
      r_dout <= w_rd_data;
    end
  end

  assign cpu_dout = r_dout;

endmodule

// File: tb/tb_tlv_encoder.sv
// Scoreboard bench for tlv_encoder: reads queue an expected word, a monitor checks cpu_dout.
module tb_tlv_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] cpu_din = '0;
  logic [63:0] cpu_ain = '0;
  logic        cpu_wren = 1'b0;
  logic [63:0] cpu_dout;
  logic        rd_req = 1'b0;

  logic [63:0]  exp_q [$];
  string        name_q [$];
  logic [191:0] exp_obuf = '0;
  int           total = 0;
  int           bad = 0;
  logic [63:0]  mon_exp;
  string        mon_name;

  tlv_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_din  (cpu_din),
    .cpu_ain  (cpu_ain),
    .cpu_wren (cpu_wren),
    .cpu_dout (cpu_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_req) begin
      #1;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_read: got %h, nothing expected", cpu_dout);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (cpu_dout !== mon_exp) begin
          bad++;
          $display("FAIL %s: got %h want %h", mon_name, cpu_dout, mon_exp);
        end
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [63:0] d);
    cpu_ain  = {61'b0, a};
    cpu_din  = d;
    cpu_wren = 1'b1;
    @(negedge clk);
    cpu_wren = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [63:0] e, input string nm);
    cpu_ain = {61'b0, a};
    rd_req  = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic put_hdr(input logic [111:0] h, input int n, input int off);
    for (int i = 0; i < n; i++) exp_obuf[191-8*(off+i) -: 8] = h[111-8*i -: 8];
  endtask

  task automatic chk_obuf(input string nm);
    rd(3'd4, exp_obuf[191:128], {nm, "_obuf_hi"});
    rd(3'd5, exp_obuf[127:64],  {nm, "_obuf_mid"});
    rd(3'd6, exp_obuf[63:0],    {nm, "_obuf_lo"});
  endtask

  task automatic run(input logic [63:0] t, input logic [63:0] l, input logic [2:0] off,
                     input logic [111:0] h, input int n, input string nm);
    wr(3'd0, t);
    wr(3'd1, l);
    wr(3'd2, {61'b0, off});
    wr(3'd3, 64'd1);
`ifdef TLV_ENC_CLEAR_EN
    exp_obuf = '0;
`endif
    put_hdr(h, n, int'(off));
    repeat (n + 1) @(negedge clk);
    rd(3'd3, 64'h100 + 64'(n), {nm, "_status"});
    rd(3'd7, 64'(n), {nm, "_voff"});
    chk_obuf(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    rd(3'd3, 64'h0, "rst_status");
    rd(3'd0, 64'h0, "rst_type");
    chk_obuf("rst");

    // 1: single-byte type and length, with cycle-exact busy/done timing
    wr(3'd0, 64'h05);
    wr(3'd1, 64'h10);
    wr(3'd2, 64'h0);
    wr(3'd3, 64'd1);
`ifdef TLV_ENC_CLEAR_EN
    exp_obuf = '0;
`endif
    put_hdr({16'h0510, 96'h0}, 2, 0);
    rd(3'd3, 64'h202, "t1_busy1");
    rd(3'd3, 64'h202, "t1_busy2");
    rd(3'd3, 64'h102, "t1_done");
    chk_obuf("t1");

    // 2: 16-bit type, 32-bit length at offset 3
    run(64'h1234, 64'h1234_5678, 3'd3, {64'hFD1234FE12345678, 48'h0}, 8, "t2");
    rd(3'd2, 64'h3, "t2_off");

    // 3: 0xFD values must take the FD form
    run(64'hFD, 64'hFD, 3'd0, {48'hFD00FDFD00FD, 64'h0}, 6, "t3");

    // 4: worst case, 32-bit type and 64-bit length at offset 7
    run(64'hABCD_EF01, 64'h1_0000_0000, 3'd7, 112'hFEABCDEF01FF0000000100000000, 14, "t4");
    rd(3'd1, 64'h1_0000_0000, "t4_len");

    // 5: config write and restart while busy are ignored
    wr(3'd0, 64'h07);
    wr(3'd1, 64'h300);
    wr(3'd2, 64'h1);
    wr(3'd3, 64'd1);
`ifdef TLV_ENC_CLEAR_EN
    exp_obuf = '0;
`endif
    put_hdr({32'h07FD0300, 80'h0}, 4, 1);
    @(negedge clk);
    wr(3'd0, 64'h99);
    wr(3'd3, 64'd1);
    repeat (2) @(negedge clk);
    rd(3'd3, 64'h104, "t5_status");
    rd(3'd0, 64'h07, "t5_type");
    chk_obuf("t5");

    // 6: reset in the middle of an encode
    wr(3'd0, 64'h42);
    wr(3'd1, 64'h1000);
    wr(3'd2, 64'h2);
    wr(3'd3, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    rd(3'd3, 64'h0, "t6_in_reset");
    rst = 1'b1;
    exp_obuf = '0;
    rd(3'd3, 64'h0, "t6_status");
    rd(3'd0, 64'h0, "t6_type");
    rd(3'd2, 64'h0, "t6_off");
    chk_obuf("t6_clr");
    run(64'h42, 64'h1000, 3'd2, {32'h42FD1000, 80'h0}, 4, "t6_re");

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending reads want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
